// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: instruction ROM port, decode handshake and execute redirect
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_inst,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_inst,
        output if_pred_taken,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_inst,
        input  if_pred_taken,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with fetch queue; optional BRANCH_PREDICT_EN static predictor
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int          CW      = $clog2(FQ_DEPTH + 1);
    localparam int          PW      = $clog2(FQ_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_q_pc   [FQ_DEPTH];
    logic [31:0]   r_q_inst [FQ_DEPTH];
    logic          r_q_pred [FQ_DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_fetch;
    logic          w_pred;
    logic [31:0]   w_next_pc;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.if_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_fetch = ~bus.redirect_valid & ((r_count < DEPTH_C) | w_pop);

    assign bus.imem_addr = r_pc;

`ifdef BRANCH_PREDICT_EN
    logic [31:0] w_bimm;
    assign w_bimm = {{20{bus.imem_inst[31]}}, bus.imem_inst[7], bus.imem_inst[30:25],
                     bus.imem_inst[11:8], 1'b0};
    // Backward conditional branches (sign bit set) are predicted taken.
    assign w_pred    = (bus.imem_inst[6:0] == 7'b1100011) & bus.imem_inst[31];
    assign w_next_pc = w_pred ? (r_pc + w_bimm) : (r_pc + 32'd4);
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = r_pc + 32'd4;
`endif

    // Head entry is muxed against empty so decode never sees stale data.
    assign bus.if_valid      = w_valid;
    assign bus.if_pc         = w_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign bus.if_inst       = w_valid ? r_q_inst[r_rd_ptr] : NOP;
    assign bus.if_pred_taken = w_valid & r_q_pred[r_rd_ptr];

    // PC, queue pointers and count; redirect flushes and overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_pc     <= bus.redirect_pc & ~32'h3;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_fetch) begin
                r_pc     <= w_next_pc;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage written at the write pointer on every fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_q_pc[i]   <= 32'h0;
                r_q_inst[i] <= NOP;
                r_q_pred[i] <= 1'b0;
            end
        end else if (w_fetch) begin
            r_q_pc[r_wr_ptr]   <= r_pc;
            r_q_inst[r_wr_ptr] <= bus.imem_inst;
            r_q_pred[r_wr_ptr] <= w_pred;
        end
    end
endmodule
